ray_result_writer: RTL and testbench

- Downstream stage of the ray marching unit.
- Captures each finished pixel (hcount, vcount, 4-bit shade) on the unit's ready pulse and buffers it in a small FIFO.
- Drains the FIFO into the framebuffer BRAM write port whenever the framebuffer arbiter grants access.
- Counts written pixels and flags frame completion, overflow and out-of-range coordinates.

---
 rtl/ray_result_writer_if.sv | 36 +++
 rtl/ray_result_writer.sv | 117 +++++++++++
 tb/tb_ray_result_writer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ray_result_writer_if.sv
// Bundles the ray-result capture inputs and framebuffer write outputs of ray_result_writer.
interface ray_result_writer_if #(
  parameter int H_BITS     = 9,
  parameter int V_BITS     = 9,
  parameter int ADDR_BITS  = 17,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

  logic                 result_valid_in;
  logic [H_BITS-1:0]    hcount_in;
  logic [V_BITS-1:0]    vcount_in;
  logic [3:0]           color_in;
  logic                 fb_grant_in;
  logic                 clear_in;
  logic                 fb_we_out;
  logic [ADDR_BITS-1:0] fb_addr_out;
  logic [3:0]           fb_data_out;
  logic [CNT_BITS-1:0]  fifo_count_out;
  logic [ADDR_BITS-1:0] pixel_count_out;
  logic                 frame_done_out;
  logic                 overflow_out;
  logic                 range_err_out;

  modport master (
    output result_valid_in, hcount_in, vcount_in, color_in, fb_grant_in, clear_in,
    input  fb_we_out, fb_addr_out, fb_data_out, fifo_count_out, pixel_count_out,
           frame_done_out, overflow_out, range_err_out
  );

  modport slave (
    input  result_valid_in, hcount_in, vcount_in, color_in, fb_grant_in, clear_in,
    output fb_we_out, fb_addr_out, fb_data_out, fifo_count_out, pixel_count_out,
           frame_done_out, overflow_out, range_err_out
  );
endinterface

// File: rtl/ray_result_writer.sv
// Buffers finished ray-marched pixels in a small FIFO and drains them into the
// framebuffer write port when the arbiter grants, tracking frame progress and errors.
module ray_result_writer #(
  parameter int DISPLAY_WIDTH  = 400,
  parameter int DISPLAY_HEIGHT = 300,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 9,
  parameter int ADDR_BITS      = 17,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  ray_result_writer_if.slave  bus
);
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [ADDR_BITS:0] FRAME_PIXELS = (ADDR_BITS+1)'(DISPLAY_WIDTH * DISPLAY_HEIGHT);

  logic [ADDR_BITS-1:0] addrMem_q [FIFO_DEPTH];
  logic [3:0]           colorMem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  wrPtr_q, rdPtr_q;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic [ADDR_BITS-1:0] pixCount_q, pixCount_d;
  logic [ADDR_BITS-1:0] fbAddr_q, fbAddr_d, pushAddr;
  logic [3:0]           fbData_q, fbData_d;
  logic                 fbWe_q, frameDone_q, frameDone_d;
  logic                 overflow_q, overflow_d, rangeErr_q, rangeErr_d;
  logic [H_BITS-1:0]    hIn;
  logic [V_BITS-1:0]    vIn;
  logic                 inRange, full, doPop, doPush;
  logic [ADDR_BITS:0]   pixBase, pixInc;

  assign hIn     = bus.hcount_in;
  assign vIn     = bus.vcount_in;
  assign inRange = (32'(hIn) < DISPLAY_WIDTH) && (32'(vIn) < DISPLAY_HEIGHT);
  assign full    = (count_q == CNT_BITS'(FIFO_DEPTH));
  assign doPop   = (count_q != '0) && bus.fb_grant_in;
  // A simultaneous pop frees the head slot, so a full FIFO still accepts the push.
  assign doPush  = bus.result_valid_in && inRange && (!full || doPop);

  // Only in-range coordinates are stored, so the truncated product cannot alias.
  assign pushAddr = ADDR_BITS'(vIn) * ADDR_BITS'(DISPLAY_WIDTH) + ADDR_BITS'(hIn);

  always_comb begin
    count_d     = count_q;
    pixBase     = bus.clear_in ? '0 : {1'b0, pixCount_q};
    pixInc      = pixBase + (ADDR_BITS+1)'(1);
    pixCount_d  = pixBase[ADDR_BITS-1:0];
    frameDone_d = 1'b0;
    fbAddr_d    = fbAddr_q;
    fbData_d    = fbData_q;

    if (doPush && !doPop) begin
      count_d = count_q + CNT_BITS'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - CNT_BITS'(1);
    end

    if (doPop) begin
      fbAddr_d = addrMem_q[rdPtr_q];
      fbData_d = colorMem_q[rdPtr_q];
      if (pixInc == FRAME_PIXELS) begin
        pixCount_d  = '0;
        frameDone_d = 1'b1;
      end else begin
        pixCount_d  = pixInc[ADDR_BITS-1:0];
      end
    end

    // A new error on the same edge as clear must survive the clear.
    overflow_d = (overflow_q && !bus.clear_in) ||
                 (bus.result_valid_in && inRange && full && !doPop);
    rangeErr_d = (rangeErr_q && !bus.clear_in) || (bus.result_valid_in && !inRange);
  end

  always_ff @(posedge clk_in) begin
    if (doPush) begin
      addrMem_q[wrPtr_q]  <= pushAddr;
      colorMem_q[wrPtr_q] <= bus.color_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      pixCount_q  <= '0;
      fbWe_q      <= 1'b0;
      fbAddr_q    <= '0;
      fbData_q    <= '0;
      frameDone_q <= 1'b0;
      overflow_q  <= 1'b0;
      rangeErr_q  <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_BITS'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_BITS'(1);
      count_q     <= count_d;
      pixCount_q  <= pixCount_d;
      fbWe_q      <= doPop;
      fbAddr_q    <= fbAddr_d;
      fbData_q    <= fbData_d;
      frameDone_q <= frameDone_d;
      overflow_q  <= overflow_d;
      rangeErr_q  <= rangeErr_d;
    end
  end

  assign bus.fb_we_out       = fbWe_q;
  assign bus.fb_addr_out     = fbAddr_q;
  assign bus.fb_data_out     = fbData_q;
  assign bus.fifo_count_out  = count_q;
  assign bus.pixel_count_out = pixCount_q;
  assign bus.frame_done_out  = frameDone_q;
  assign bus.overflow_out    = overflow_q;
  assign bus.range_err_out   = rangeErr_q;
endmodule

// File: tb/tb_ray_result_writer.sv
// Self-checking bench for ray_result_writer: a full-size instance against a queue model
// and a tiny 4x2 instance driven from a vector table for frame completion.
module tb_ray_result_writer;
  localparam int AW    = 400;
  localparam int AH    = 300;
  localparam int DEPTH = 4;
  localparam int TOTAL = AW * AH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nChecks;
  int nFails;

  ray_result_writer_if #(.H_BITS(9), .V_BITS(9), .ADDR_BITS(17), .FIFO_DEPTH(DEPTH)) busA ();
  ray_result_writer_if #(.H_BITS(9), .V_BITS(9), .ADDR_BITS(3),  .FIFO_DEPTH(DEPTH)) busB ();

  ray_result_writer #(
    .DISPLAY_WIDTH(AW), .DISPLAY_HEIGHT(AH), .H_BITS(9), .V_BITS(9),
    .ADDR_BITS(17), .FIFO_DEPTH(DEPTH)
  ) dutA (.clk_in(clk), .rst_in(rst_n), .bus(busA));

  ray_result_writer #(
    .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2), .H_BITS(9), .V_BITS(9),
    .ADDR_BITS(3), .FIFO_DEPTH(DEPTH)
  ) dutB (.clk_in(clk), .rst_in(rst_n), .bus(busB));

  // Reference model: a plain queue of pending writes plus the observable registers.
  typedef struct { int addr; int data; } entry_t;
  entry_t mq[$];
  int mAddr, mData, mPix;
  bit mWe, mDone, mOvf, mRerr;

  typedef struct {
    bit valid; int h; int v; int c; bit grant;
    bit we; int addr; int data; int count; int pix; bit done;
  } vec_t;
  vec_t vecs[10];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mAddr = 0; mData = 0; mPix = 0;
    mWe = 0; mDone = 0; mOvf = 0; mRerr = 0;
  endtask

  task automatic modelStep(input bit valid, input int h, input int v, input int c,
                           input bit grant, input bit clear);
    entry_t e;
    bit pop;
    pop   = grant && (mq.size() > 0);
    mWe   = pop;
    mDone = 0;
    if (clear) begin
      mPix = 0; mOvf = 0; mRerr = 0;
    end
    if (pop) begin
      e     = mq.pop_front();
      mAddr = e.addr;
      mData = e.data;
      mPix  = (mPix + 1) % TOTAL;
      mDone = (mPix == 0);
    end
    if (valid) begin
      if (h >= AW || v >= AH) mRerr = 1;
      else if (mq.size() < DEPTH) begin
        e.addr = v * AW + h;
        e.data = c;
        mq.push_back(e);
      end else mOvf = 1;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".we"},    32'(busA.fb_we_out),       32'(mWe));
    checkVal({tag, ".addr"},  32'(busA.fb_addr_out),     32'(mAddr));
    checkVal({tag, ".data"},  32'(busA.fb_data_out),     32'(mData));
    checkVal({tag, ".count"}, 32'(busA.fifo_count_out),  32'(mq.size()));
    checkVal({tag, ".pix"},   32'(busA.pixel_count_out), 32'(mPix));
    checkVal({tag, ".done"},  32'(busA.frame_done_out),  32'(mDone));
    checkVal({tag, ".ovf"},   32'(busA.overflow_out),    32'(mOvf));
    checkVal({tag, ".rerr"},  32'(busA.range_err_out),   32'(mRerr));
  endtask

  task automatic applyStimulus(input bit valid, input int h, input int v, input int c,
                               input bit grant, input bit clear, input string tag);
    busA.result_valid_in = valid;
    busA.hcount_in       = 9'(h);
    busA.vcount_in       = 9'(v);
    busA.color_in        = 4'(c);
    busA.fb_grant_in     = grant;
    busA.clear_in        = clear;
    modelStep(valid, h, v, c, grant, clear);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".we"},    32'(busA.fb_we_out),       0);
    checkVal({tag, ".addr"},  32'(busA.fb_addr_out),     0);
    checkVal({tag, ".data"},  32'(busA.fb_data_out),     0);
    checkVal({tag, ".count"}, 32'(busA.fifo_count_out),  0);
    checkVal({tag, ".pix"},   32'(busA.pixel_count_out), 0);
    checkVal({tag, ".done"},  32'(busA.frame_done_out),  0);
    checkVal({tag, ".ovf"},   32'(busA.overflow_out),    0);
    checkVal({tag, ".rerr"},  32'(busA.range_err_out),   0);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    // Tiny 4x2 frame: pixel k pushed on edge k with color k+1, written one edge later.
    vecs[0] = '{1, 0, 0, 1, 1,  0, 0, 0, 1, 0, 0};
    vecs[1] = '{1, 1, 0, 2, 1,  1, 0, 1, 1, 1, 0};
    vecs[2] = '{1, 2, 0, 3, 1,  1, 1, 2, 1, 2, 0};
    vecs[3] = '{1, 3, 0, 4, 1,  1, 2, 3, 1, 3, 0};
    vecs[4] = '{1, 0, 1, 5, 1,  1, 3, 4, 1, 4, 0};
    vecs[5] = '{1, 1, 1, 6, 1,  1, 4, 5, 1, 5, 0};
    vecs[6] = '{1, 2, 1, 7, 1,  1, 5, 6, 1, 6, 0};
    vecs[7] = '{1, 3, 1, 8, 1,  1, 6, 7, 1, 7, 0};
    vecs[8] = '{0, 0, 0, 0, 1,  1, 7, 8, 0, 0, 1};
    vecs[9] = '{0, 0, 0, 0, 1,  0, 7, 8, 0, 0, 0};

    busA.result_valid_in = 0; busA.hcount_in = '0; busA.vcount_in = '0;
    busA.color_in = '0; busA.fb_grant_in = 0; busA.clear_in = 0;
    busB.result_valid_in = 0; busB.hcount_in = '0; busB.vcount_in = '0;
    busB.color_in = '0; busB.fb_grant_in = 0; busB.clear_in = 0;
    modelReset();

    #3;
    checkAllZero("reset");
    checkVal("resetB.count", 32'(busB.fifo_count_out), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    applyStimulus(0, 0, 0, 0, 1, 0, "postRelease");

    // Basic write: 140*400+150 = 56150, two cycles after the push.
    applyStimulus(1, 150, 140, 9, 1, 0, "basic.push");
    checkVal("basic.noWriteYet", 32'(busA.fb_we_out), 0);
    applyStimulus(0, 0, 0, 0, 1, 0, "basic.write");
    checkVal("basic.we",   32'(busA.fb_we_out), 1);
    checkVal("basic.addr", 32'(busA.fb_addr_out), 56150);
    checkVal("basic.data", 32'(busA.fb_data_out), 9);
    checkVal("basic.pix",  32'(busA.pixel_count_out), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, "basic.after");
    checkVal("basic.singlePulse", 32'(busA.fb_we_out), 0);

    // Backpressure: five pushes into a 4-deep FIFO, fifth dropped.
    for (int i = 1; i <= 5; i++) applyStimulus(1, 10 + i, 20, i, 0, 0, "bp.push");
    checkVal("bp.count", 32'(busA.fifo_count_out), 4);
    checkVal("bp.ovf",   32'(busA.overflow_out), 1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, "bp.drain");
      checkVal("bp.we",    32'(busA.fb_we_out), 1);
      checkVal("bp.color", 32'(busA.fb_data_out), 32'(i));
    end
    applyStimulus(0, 0, 0, 0, 1, 0, "bp.idle");
    checkVal("bp.noFifth", 32'(busA.fb_we_out), 0);
    applyStimulus(0, 0, 0, 0, 0, 1, "bp.clear");
    checkVal("bp.ovfCleared", 32'(busA.overflow_out), 0);

    // Full FIFO with push and pop on the same edge.
    for (int i = 6; i <= 9; i++) applyStimulus(1, i, 30, i, 0, 0, "full.fill");
    applyStimulus(1, 50, 30, 10, 1, 0, "full.pushPop");
    checkVal("full.count", 32'(busA.fifo_count_out), 4);
    checkVal("full.noOvf", 32'(busA.overflow_out), 0);
    checkVal("full.head",  32'(busA.fb_data_out), 6);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0, "full.drain");
    checkVal("full.lastColor", 32'(busA.fb_data_out), 10);
    checkVal("full.lastAddr",  32'(busA.fb_addr_out), 12050);

    // Out-of-range coordinates on each axis.
    applyStimulus(1, 400, 10, 3, 1, 0, "range.h");
    applyStimulus(1, 5, 300, 3, 1, 0, "range.v");
    checkVal("range.rerr",  32'(busA.range_err_out), 1);
    checkVal("range.noWe",  32'(busA.fb_we_out), 0);
    checkVal("range.count", 32'(busA.fifo_count_out), 0);
    applyStimulus(0, 0, 0, 0, 0, 1, "range.clear");
    checkVal("range.cleared", 32'(busA.range_err_out), 0);

    // Clear coinciding with a pop and with a new range error.
    applyStimulus(1, 1, 1, 5, 0, 0, "clr.fill");
    applyStimulus(1, 400, 0, 1, 1, 1, "clr.same");
    checkVal("clr.pixOne",  32'(busA.pixel_count_out), 1);
    checkVal("clr.errWins", 32'(busA.range_err_out), 1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 9) < 6), $urandom_range(0, 419), $urandom_range(0, 309),
                    $urandom_range(0, 15), 1'($urandom_range(0, 9) < 4),
                    1'($urandom_range(0, 31) == 0), "rand");
    end

    // Asynchronous reset with results still buffered.
    for (int i = 0; i < 3; i++) applyStimulus(1, i, 7, i + 1, 0, 0, "rst.fill");
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("rst.async");
    modelReset();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, "rst.after");
      checkVal("rst.noWrite", 32'(busA.fb_we_out), 0);
    end

    busA.result_valid_in = 0;
    busA.fb_grant_in     = 0;
    busA.clear_in        = 0;
    for (int i = 0; i < 10; i++) begin
      busB.result_valid_in = vecs[i].valid;
      busB.hcount_in       = 9'(vecs[i].h);
      busB.vcount_in       = 9'(vecs[i].v);
      busB.color_in        = 4'(vecs[i].c);
      busB.fb_grant_in     = vecs[i].grant;
      busB.clear_in        = 0;
      @(posedge clk);
      #1;
      checkVal($sformatf("frame[%0d].we", i),    32'(busB.fb_we_out),       32'(vecs[i].we));
      checkVal($sformatf("frame[%0d].addr", i),  32'(busB.fb_addr_out),     32'(vecs[i].addr));
      checkVal($sformatf("frame[%0d].data", i),  32'(busB.fb_data_out),     32'(vecs[i].data));
      checkVal($sformatf("frame[%0d].count", i), 32'(busB.fifo_count_out),  32'(vecs[i].count));
      checkVal($sformatf("frame[%0d].pix", i),   32'(busB.pixel_count_out), 32'(vecs[i].pix));
      checkVal($sformatf("frame[%0d].done", i),  32'(busB.frame_done_out),  32'(vecs[i].done));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
